if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
- Instruction-fetch stage between the PC/ROM side and the IF/ID decode register of the riscv_soc core.
- Owns the fetch PC, issues word addresses to the synchronous instruction ROM, and queues returned instructions in a small prefetch FIFO.
- Presents the queued instructions to decode over a valid/ready handshake.
- Applies jump redirects from ctrl: flushes queued and in-flight fetches and restarts fetch at the jump target.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
NOP_INST, 32'h0000_0013, value driven on inst_o when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
jump_en_i  in  1  redirect request from ctrl
jump_addr_i  in  32  redirect target
id_ready_i  in  1  decode accepts inst_o this cycle
rom_req_o  out  1  ROM read request
rom_addr_o  out  32  ROM byte address, bits[1:0]=0
rom_data_i  in  32  ROM data, valid the cycle after its request
inst_valid_o  out  1  FIFO head valid
inst_o  out  32  FIFO head instruction, NOP_INST when invalid
inst_addr_o  out  32  FIFO head address, 0 when invalid
pc_o  out  32  next fetch PC (debug/trace)

Behaviour:
- Reset: clk and rstn are as stated in the Ports list; reset is synchronous, active-low. While rstn=0, all of the following hold:
  - pc=RESET_PC, FIFO empty, no in-flight read.
  - rom_req_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, pc_o=RESET_PC.
  - Reset mid-operation discards all state the same way.
- First request: in the first cycle with rstn=1, rom_addr_o=RESET_PC.
- ROM model: synchronous, fixed latency 1. A request in cycle N returns rom_data_i in cycle N+1. rom_data_i is written into the FIFO at the end of cycle N+1 together with its address. It is visible on inst_o from cycle N+2; there is no bypass.
- Issue rule, normal cycle: rom_req_o=1 iff occupancy + inflight - pop < DEPTH.
  - pop = inst_valid_o & id_ready_i.
  - inflight = request issued in the previous cycle and not killed.
  - On issue: rom_addr_o=pc, and pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Steady state with id_ready_i=1 sustains one instruction per cycle.
- Handshake:
  - inst_valid_o = (occupancy>0).
  - The head is removed only on pop.
  - When id_ready_i=0, head and outputs stay stable.
  - inst_o and inst_addr_o never change while inst_valid_o=1 and id_ready_i=0.
- Jump, cycle J with jump_en_i=1 (highest priority, overrides stall and pop):
  - The FIFO is emptied at the end of cycle J.
  - Any response arriving in cycle J (from the request of J-1) is discarded.
  - The same cycle J, rom_req_o=1 and rom_addr_o={jump_addr_i[31:2],2'b00}; pc <= that value +4.
  - Target instruction: inst_valid_o=0 in cycle J+1, target instruction on inst_o with inst_valid_o=1 in cycle J+2.
  - A pop in cycle J is still consumed by decode. ctrl is responsible for squashing it.
  - The FIFO does not retain the popped entry.
- Back-to-back jumps (J and J+1): the second wins. The response in J+1 (first target) is discarded; the fetch is restarted at the second target.
- Occupancy counter width is clog2(DEPTH)+1. Simultaneous push and pop leaves occupancy unchanged. A push is never issued into a full FIFO: the issue rule guarantees space. The bench asserts no overflow.
- pc_o = registered pc (next address to fetch).

Test Plan:
- Reset/start: rstn low 1.5 cycles, then high, ROM[0..3]=0x00500093,0x00100113,0x002081b3,0x00000013 with id_ready_i=1 → rom_addr_o 0,4,8,12 on consecutive cycles; inst_valid_o from 2nd cycle after release; inst_addr_o 0,4,8,12 on consecutive cycles, inst_o matches ROM.
- Stall: id_ready_i=0 for 4 cycles after first valid → inst_o held at 0x00500093/addr 0, at most DEPTH=2 entries plus no extra requests (rom_req_o=0 once occupancy+inflight=2); release resumes addr 4 next cycle, no loss or duplication.
- Jump: jump_en_i=1, jump_addr_i=0x40 in cycle J while FIFO holds addr 8,12 → rom_addr_o=0x40 in J, inst_valid_o=0 in J+1, inst_addr_o=0x40 in J+2, then 0x44; addresses 8,12,16 never appear after J.
- Jump during stall with misaligned target: id_ready_i=0, FIFO full, jump_addr_i=0x102 → fetch at 0x100, FIFO flushed, inst_addr_o=0x100 at J+2.
- Back-to-back jumps: targets 0x80 (J) then 0xC0 (J+1) → 0x80 never delivered, inst_addr_o=0xC0 at J+3.
- Wrap and mid-run reset: jump to 0xFFFF_FFFC → next rom_addr_o=0x0; assert rstn=0 for 1 cycle mid-stream → all outputs return to reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_buffer_if.sv
// rtl/if_fetch_buffer_if.sv - signal bundle between the fetch stage, instruction ROM, ctrl and decode
//
// Purpose: groups every non-clock/reset signal of if_fetch_buffer so the fetch
// stage and its surroundings connect through one port.
//
// Signals (direction seen from the fetch stage, modport master):
//   jump_en_i     in   1   redirect request from ctrl
//   jump_addr_i   in  32   redirect target (bits [1:0] ignored)
//   id_ready_i    in   1   decode accepts inst_o this cycle
//   rom_req_o     out  1   ROM read request
//   rom_addr_o    out 32   ROM byte address, word aligned
//   rom_data_i    in  32   ROM data, valid the cycle after its request
//   inst_valid_o  out  1   FIFO head valid
//   inst_o        out 32   FIFO head instruction, NOP when invalid
//   inst_addr_o   out 32   FIFO head address, 0 when invalid
//   pc_o          out 32   next fetch PC (debug/trace)
//
// Modport slave is the mirror view used by the ROM/ctrl/decode side.

interface if_fetch_buffer_if;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        id_ready_i;
   logic        rom_req_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic [31:0] pc_o;

   modport master (
      input  jump_en_i,
      input  jump_addr_i,
      input  id_ready_i,
      input  rom_data_i,
      output rom_req_o,
      output rom_addr_o,
      output inst_valid_o,
      output inst_o,
      output inst_addr_o,
      output pc_o
   );

   modport slave (
      output jump_en_i,
      output jump_addr_i,
      output id_ready_i,
      output rom_data_i,
      input  rom_req_o,
      input  rom_addr_o,
      input  inst_valid_o,
      input  inst_o,
      input  inst_addr_o,
      input  pc_o
   );
endinterface

// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - instruction fetch stage with prefetch FIFO and jump redirect
//
// Purpose: owns the fetch PC, issues word reads to a latency-1 synchronous
// instruction ROM, queues returned instructions with their addresses in a
// DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
// A jump from ctrl empties the FIFO, kills the in-flight read and restarts
// fetch at the (word-aligned) target in the same cycle.
//
// Ports:
//   clk    in   1   clock
//   rstn   in   1   synchronous active-low reset
//   bus    if       if_fetch_buffer_if.master: ctrl redirect, ROM request/
//                   response, decode handshake and pc_o trace output
//
// Parameters:
//   RESET_PC  fetch address after reset
//   DEPTH     prefetch FIFO entries, power of two, >= 2
//   NOP_INST  value on inst_o whenever the head is not valid

module if_fetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rstn,
   if_fetch_buffer_if.master  bus
);

   localparam int             PW      = $clog2(DEPTH);
   localparam int             CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

   // Fetch PC and FIFO storage.
   logic [31:0]   pc_q;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   addr_mem [DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;

   // One read can be outstanding; its address travels with it so the FIFO
   // entry carries the PC of the instruction it holds.
   logic          inflight_q;
   logic [31:0]   inflight_addr_q;

   logic          jump;
   logic [31:0]   jump_target;
   logic          head_valid;
   logic          pop;
   logic          push;
   logic [CW:0]   demand;
   logic          issue;
   logic [31:0]   fetch_addr;

   always_comb begin
      jump        = rstn & bus.jump_en_i;
      // Masking the whole word keeps every target bit in use; bits [1:0]
      // are simply forced to zero.
      jump_target = bus.jump_addr_i & 32'hFFFF_FFFC;
      head_valid  = rstn & (count_q != '0);
      pop         = head_valid & bus.id_ready_i;
      // A returning word is dropped when a jump lands in the same cycle:
      // it belongs to the stream being abandoned.
      push        = inflight_q & ~jump;
      // Entries that will exist once everything already promised lands,
      // minus the one decode takes this cycle. Issuing only while this is
      // below DEPTH is what guarantees a push never finds the FIFO full.
      demand      = {1'b0, count_q}
                  + {{CW{1'b0}}, inflight_q}
                  - {{CW{1'b0}}, pop};
      issue       = rstn & (jump | (demand < DEPTH_W));
      fetch_addr  = !rstn ? RESET_PC : (jump ? jump_target : pc_q);
   end

   assign bus.rom_req_o    = issue;
   assign bus.rom_addr_o   = fetch_addr;
   assign bus.inst_valid_o = head_valid;
   assign bus.inst_o       = head_valid ? data_mem[rd_ptr_q] : NOP_INST;
   assign bus.inst_addr_o  = head_valid ? addr_mem[rd_ptr_q] : 32'h0;
   assign bus.pc_o         = rstn ? pc_q : RESET_PC;

   // Control state. Jump wins over stall and pop: the FIFO is emptied and
   // the read issued this cycle at the target becomes the only one in flight.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q            <= RESET_PC;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= RESET_PC;
      end else if (jump) begin
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         inflight_q      <= 1'b1;
         inflight_addr_q <= jump_target;
         pc_q            <= jump_target + 32'd4;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q    <= count_q + CW'(push) - CW'(pop);
         inflight_q <= issue;
         if (issue) begin
            inflight_addr_q <= pc_q;
            // 32-bit add wraps 0xFFFF_FFFC back to 0.
            pc_q            <= pc_q + 32'd4;
         end
      end
   end

   // FIFO payload needs no reset: count_q gates every read of it.
   always_ff @(posedge clk) begin
      if (rstn && push) begin
         data_mem[wr_ptr_q] <= bus.rom_data_i;
         addr_mem[wr_ptr_q] <= inflight_addr_q;
      end
   end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb/tb_if_fetch_buffer.sv - scoreboard bench for if_fetch_buffer

module tb_if_fetch_buffer;

   logic clk;
   logic rstn;
   int   tests;
   int   fails;

   logic [31:0] exp_q [$];
   logic [31:0] rom_next;
   logic        hold_prev;
   logic [31:0] prev_inst;
   logic [31:0] prev_addr;

   if_fetch_buffer_if bus ();

   if_fetch_buffer #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: rom_word = 32'h0050_0093;
         32'h0000_0004: rom_word = 32'h0010_0113;
         32'h0000_0008: rom_word = 32'h0020_81b3;
         32'h0000_000C: rom_word = 32'h0000_0013;
         default:       rom_word = a ^ 32'h5A5A_0000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ROM: answer the request seen during a cycle on the following edge.
   always @(negedge clk) begin
      rom_next = bus.rom_req_o ? rom_word(bus.rom_addr_o) : 32'hDEAD_BEEF;
   end
   always @(posedge clk) begin
      bus.rom_data_i <= rom_next;
   end

   // Monitor: every accepted instruction must be the next expected address.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rstn && bus.inst_valid_o && bus.id_ready_i) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pop: got addr %h, expected no delivery", bus.inst_addr_o);
         end else begin
            e = exp_q.pop_front();
            check("pop_addr", bus.inst_addr_o, e);
            check("pop_data", bus.inst_o, rom_word(e));
         end
      end
      if (rstn && hold_prev && bus.inst_valid_o) begin
         check("stall_hold_inst", bus.inst_o, prev_inst);
         check("stall_hold_addr", bus.inst_addr_o, prev_addr);
      end
      hold_prev = rstn && bus.inst_valid_o && !bus.id_ready_i;
      prev_inst = bus.inst_o;
      prev_addr = bus.inst_addr_o;
   end

   task automatic cyc(input logic rst_n, input logic rdy, input logic jmp, input logic [31:0] ja);
      @(posedge clk);
      #1;
      rstn            = rst_n;
      bus.id_ready_i  = rdy;
      bus.jump_en_i   = jmp;
      bus.jump_addr_i = ja;
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_rom_req"},    32'(bus.rom_req_o),    32'h0);
      check({tag, "_inst_valid"}, 32'(bus.inst_valid_o), 32'h0);
      check({tag, "_inst"},       bus.inst_o,            32'h0000_0013);
      check({tag, "_inst_addr"},  bus.inst_addr_o,       32'h0);
      check({tag, "_pc"},         bus.pc_o,              32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tests           = 0;
      fails           = 0;
      hold_prev       = 1'b0;
      rstn            = 1'b0;
      bus.id_ready_i  = 1'b0;
      bus.jump_en_i   = 1'b0;
      bus.jump_addr_i = 32'h0;
      bus.rom_data_i  = 32'h0;

      // Reset and start-up stream.
      cyc(0, 1, 0, 32'h0);
      chk_reset("reset");
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h8); exp_q.push_back(32'hC);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, 32'h0);
         if (i < 4) begin
            check("start_rom_req",  32'(bus.rom_req_o), 32'h1);
            check("start_rom_addr", bus.rom_addr_o,     32'(i * 4));
         end
         if (i < 2) check("start_not_valid", 32'(bus.inst_valid_o), 32'h0);
         else       check("start_inst_addr", bus.inst_addr_o,       32'((i - 2) * 4));
      end

      // Reset pulse mid-stream, then stall with a full FIFO.
      cyc(0, 1, 0, 32'h0);
      chk_reset("midreset1");
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      cyc(1, 1, 0, 32'h0);
      check("restart_rom_addr", bus.rom_addr_o, 32'h0);
      cyc(1, 1, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 32'h0);
         check("stall_valid",     32'(bus.inst_valid_o), 32'h1);
         check("stall_inst",      bus.inst_o,            32'h0050_0093);
         check("stall_inst_addr", bus.inst_addr_o,       32'h0);
         if (i > 0) check("stall_no_req", 32'(bus.rom_req_o), 32'h0);
      end
      cyc(1, 1, 0, 32'h0);
      check("release_rom_addr", bus.rom_addr_o, 32'h8);
      cyc(1, 1, 0, 32'h0);
      check("release_inst_addr", bus.inst_addr_o, 32'h4);
      cyc(1, 0, 0, 32'h0);

      // Jump to 0x40 while FIFO holds 8,12 (8 is popped in the jump cycle).
      exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
      cyc(1, 1, 1, 32'h40);
      check("jump_rom_req",  32'(bus.rom_req_o), 32'h1);
      check("jump_rom_addr", bus.rom_addr_o,     32'h40);
      cyc(1, 1, 0, 32'h0);
      check("jump_j1_valid",    32'(bus.inst_valid_o), 32'h0);
      check("jump_j1_rom_addr", bus.rom_addr_o,        32'h44);
      cyc(1, 1, 0, 32'h0);
      check("jump_j2_inst_addr", bus.inst_addr_o, 32'h40);
      cyc(1, 1, 0, 32'h0);
      check("jump_j3_inst_addr", bus.inst_addr_o, 32'h44);
      cyc(1, 1, 0, 32'h0);

      // Jump during stall with a misaligned target.
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      cyc(1, 0, 0, 32'h0);
      cyc(1, 0, 1, 32'h102);
      check("stalljump_full",     32'(bus.inst_valid_o), 32'h1);
      check("stalljump_rom_addr", bus.rom_addr_o,        32'h100);
      cyc(1, 0, 0, 32'h0);
      check("stalljump_j1_valid", 32'(bus.inst_valid_o), 32'h0);
      cyc(1, 1, 0, 32'h0);
      check("stalljump_j2_inst_addr", bus.inst_addr_o, 32'h100);
      cyc(1, 1, 0, 32'h0);

      // Back-to-back jumps: 0x80 then 0xC0.
      exp_q.push_back(32'h108); exp_q.push_back(32'hC0);
      exp_q.push_back(32'hC4);  exp_q.push_back(32'hC8);
      cyc(1, 1, 1, 32'h80);
      check("b2b_rom_addr1", bus.rom_addr_o, 32'h80);
      cyc(1, 1, 1, 32'hC0);
      check("b2b_rom_addr2", bus.rom_addr_o,        32'hC0);
      check("b2b_j1_valid",  32'(bus.inst_valid_o), 32'h0);
      cyc(1, 1, 0, 32'h0);
      check("b2b_j2_valid",  32'(bus.inst_valid_o), 32'h0);
      cyc(1, 1, 0, 32'h0);
      check("b2b_j3_inst_addr", bus.inst_addr_o, 32'hC0);
      cyc(1, 1, 0, 32'h0);

      // PC wrap at the top of the address space.
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
      cyc(1, 1, 1, 32'hFFFF_FFFC);
      check("wrap_rom_addr", bus.rom_addr_o, 32'hFFFF_FFFC);
      cyc(1, 1, 0, 32'h0);
      check("wrap_next_rom_addr", bus.rom_addr_o, 32'h0);
      check("wrap_pc",            bus.pc_o,       32'h0);
      cyc(1, 1, 0, 32'h0);
      check("wrap_inst_addr", bus.inst_addr_o, 32'hFFFF_FFFC);
      cyc(1, 1, 0, 32'h0);
      check("wrap_inst_addr0", bus.inst_addr_o, 32'h0);

      // Mid-stream reset, fetch restarts at RESET_PC.
      cyc(0, 1, 0, 32'h0);
      chk_reset("midreset2");
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      cyc(1, 1, 0, 32'h0);
      check("rerun_rom_addr", bus.rom_addr_o, 32'h0);
      cyc(1, 1, 0, 32'h0);
      check("rerun_not_valid", 32'(bus.inst_valid_o), 32'h0);
      cyc(1, 1, 0, 32'h0);
      check("rerun_inst_addr0", bus.inst_addr_o, 32'h0);
      cyc(1, 1, 0, 32'h0);
      check("rerun_inst_addr4", bus.inst_addr_o, 32'h4);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
